// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 key event queue: parser states,
// scan prefix bytes, the queued event layout and read_data bit positions.
package kbd_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } parse_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } kbd_event_t;

   localparam int EV_W = $bits(kbd_event_t);

   localparam int RD_CODE_LSB  = 0;
   localparam int RD_EXT_BIT   = 8;
   localparam int RD_BRK_BIT   = 9;
   localparam int RD_VALID_BIT = 10;
   localparam int RD_OVF_BIT   = 11;

endpackage

// File: rtl/ps2_key_event_queue_sync_fifo.sv
// Synchronous FIFO with a registered head word (zero when empty) and a sticky
// overflow flag; a push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter  int DATA_W = 10,
   parameter  int DEPTH  = 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              clr_ovf,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] head,
   output logic              nonempty,
   output logic              overflow
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [AW:0]       count, count_nxt;
   logic [DATA_W-1:0] head_nxt;
   logic              full, do_push, do_pop, ovf_set;

   always_comb begin
      full       = (count == FULL_CNT);
      do_pop     = pop && (count != '0);
      do_push    = push && (!full || do_pop);
      ovf_set    = push && !do_push;
      rd_ptr_nxt = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
      unique case ({do_push, do_pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
      // The slot about to become head may be the one being written this cycle.
      if (count_nxt == '0)
         head_nxt = '0;
      else if (do_push && (rd_ptr_nxt == wr_ptr))
         head_nxt = data_in;
      else
         head_nxt = mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         head     <= '0;
         nonempty <= 1'b0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         head     <= head_nxt;
         nonempty <= (count_nxt != '0);
         if (ovf_set)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scan byte parser feeding an event FIFO read by the CPU as a 32-bit word.
// Optional typematic repeat suppression is built when KBD_REPEAT_FILTER_EN is defined.
module ps2_key_event_queue
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  scan_code,
   input  logic        scan_valid,
   input  logic        rd_en,
   output logic [31:0] read_data,
   output logic        irq_pending
);

   parse_state_t state, state_nxt;
   kbd_event_t   ev, head;
   logic         ev_push, fifo_push;
   logic         nonempty, overflow;
   logic [EV_W-1:0] head_raw;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (scan_valid) begin
         unique case (state)
            S_IDLE: begin
               if (scan_code == PS2_EXT)      state_nxt = S_EXT;
               else if (scan_code == PS2_BRK) state_nxt = S_BRK;
            end
            S_EXT: begin
               if (scan_code == PS2_BRK)      state_nxt = S_EXT_BRK;
               else if (scan_code != PS2_EXT) state_nxt = S_IDLE;
            end
            S_BRK: begin
               if (scan_code == PS2_EXT)      state_nxt = S_EXT_BRK;
               else if (scan_code != PS2_BRK) state_nxt = S_IDLE;
            end
            S_EXT_BRK: begin
               if (scan_code != PS2_EXT && scan_code != PS2_BRK) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Any non-prefix byte terminates the sequence; the state so far supplies ext/brk.
   always_comb begin
      ev      = '0;
      ev_push = 1'b0;
      if (scan_valid && scan_code != PS2_EXT && scan_code != PS2_BRK) begin
         ev_push = 1'b1;
         ev.code = scan_code;
         ev.ext  = (state == S_EXT) || (state == S_EXT_BRK);
         ev.brk  = (state == S_BRK) || (state == S_EXT_BRK);
      end
   end

`ifdef KBD_REPEAT_FILTER_EN
   logic [8:0] last_make;
   logic       last_vld, last_hit;

   always_comb begin
      last_hit  = last_vld && ({ev.ext, ev.code} == last_make);
      fifo_push = ev_push && !(last_hit && !ev.brk);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_vld <= 1'b0;
      end else if (fifo_push && !ev.brk) begin
         last_make <= {ev.ext, ev.code};
         last_vld  <= 1'b1;
      end else if (ev_push && ev.brk && last_hit) begin
         last_vld <= 1'b0;
      end
   end
`else
   always_comb fifo_push = ev_push;
`endif

   sync_fifo #(
      .DATA_W (EV_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .pop      (rd_en),
      .clr_ovf  (rd_en),
      .data_in  (ev),
      .head     (head_raw),
      .nonempty (nonempty),
      .overflow (overflow)
   );

   always_comb begin
      head                           = kbd_event_t'(head_raw);
      read_data                      = '0;
      read_data[RD_CODE_LSB +: 8]    = head.code;
      read_data[RD_EXT_BIT]          = head.ext;
      read_data[RD_BRK_BIT]          = head.brk;
      read_data[RD_VALID_BIT]        = nonempty;
      read_data[RD_OVF_BIT]          = overflow;
      irq_pending                    = nonempty;
   end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: expected events go into a scoreboard
// queue as bytes are sent and are compared against read_data as they are read.
module tb_ps2_key_event_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  scan_code;
   logic        scan_valid;
   logic        rd_en;
   logic [31:0] read_data;
   logic        irq_pending;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   ps2_key_event_queue #(.DEPTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .scan_code   (scan_code),
      .scan_valid  (scan_valid),
      .rd_en       (rd_en),
      .read_data   (read_data),
      .irq_pending (irq_pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      scan_code  = b;
      scan_valid = 1'b1;
      tick();
      scan_valid = 1'b0;
   endtask

   task automatic read();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic expect_ev(input logic brk, input logic ext, input logic [7:0] code);
      exp_q.push_back({brk, ext, code});
   endtask

   // Read until the scoreboard is empty, then confirm the DUT is empty too.
   task automatic drain(input string tag);
      logic [9:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, {21'd0, read_data[10:0]}, {21'd0, 1'b1, e});
         read();
      end
      check({tag, "_empty"}, read_data, 32'h0);
      check({tag, "_irq"}, {31'd0, irq_pending}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      scan_code  = 8'h00;
      scan_valid = 1'b0;
      rd_en      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("reset_rd", read_data, 32'h0);
      check("reset_irq", {31'd0, irq_pending}, 32'd0);

      send(8'h1C);
      check("make_rd", read_data, 32'h0000_041C);
      check("make_irq", {31'd0, irq_pending}, 32'd1);
      read();
      check("pop_rd", read_data, 32'h0);
      check("pop_irq", {31'd0, irq_pending}, 32'd0);

      send(8'hF0); send(8'h1C);
      check("brk_rd", read_data, 32'h0000_061C);
      read();
      send(8'hE0); send(8'hF0); send(8'h75);
      check("extbrk_rd", read_data, 32'h0000_0775);
      read();
      send(8'hF0); send(8'hE0); send(8'h6B);
      expect_ev(1'b1, 1'b1, 8'h6B);
      send(8'hE0); send(8'hE0); send(8'h75);
      expect_ev(1'b0, 1'b1, 8'h75);
      send(8'hF0); send(8'hF0); send(8'h12);
      expect_ev(1'b1, 1'b0, 8'h12);
      drain("prefix");

      read();
      check("rd_empty", read_data, 32'h0);

      for (int i = 1; i <= 9; i++) begin
         send(8'(i));
         if (i <= 8) expect_ev(1'b0, 1'b0, 8'(i));
      end
      check("ovf_head", read_data, 32'h0000_0C01);
      check("ovf_first", {21'd0, read_data[10:0]}, {21'd0, 1'b1, exp_q.pop_front()});
      read();
      check("ovf_clear", {31'd0, read_data[11]}, 32'd0);
      drain("ovf_drain");

      for (int i = 0; i < 8; i++) begin
         send(8'h11 + 8'(i));
         expect_ev(1'b0, 1'b0, 8'h11 + 8'(i));
      end
      check("full_head", read_data, 32'h0000_0411);
      scan_code  = 8'h19;
      scan_valid = 1'b1;
      rd_en      = 1'b1;
      tick();
      scan_valid = 1'b0;
      rd_en      = 1'b0;
      void'(exp_q.pop_front());
      expect_ev(1'b0, 1'b0, 8'h19);
      check("full_both", read_data, 32'h0000_0412);
      drain("full_drain");

      send(8'h21); send(8'h22); send(8'hE0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset_rd", read_data, 32'h0);
      send(8'h1C);
      check("midreset_ev", read_data, 32'h0000_041C);
      expect_ev(1'b0, 1'b0, 8'h1C);
      drain("midreset_drain");

      send(8'h1C); send(8'h1C); send(8'h1C);
      send(8'hF0); send(8'h1C);
      send(8'h1C);
`ifdef KBD_REPEAT_FILTER_EN
      expect_ev(1'b0, 1'b0, 8'h1C);
      expect_ev(1'b1, 1'b0, 8'h1C);
      expect_ev(1'b0, 1'b0, 8'h1C);
`else
      expect_ev(1'b0, 1'b0, 8'h1C);
      expect_ev(1'b0, 1'b0, 8'h1C);
      expect_ev(1'b0, 1'b0, 8'h1C);
      expect_ev(1'b1, 1'b0, 8'h1C);
      expect_ev(1'b0, 1'b0, 8'h1C);
`endif
      drain("repeat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
